// File: rtl/ce_divider_bank_pkg.sv
// Shared constants for the clock-enable divider bank.
package ce_divider_bank_pkg;

  localparam int unsigned DEF_WIDTH = 25;
  localparam int unsigned DEF_DIV   = 20000000;
  localparam int unsigned MAX_CH    = 8;

endpackage

// File: rtl/ce_divider_bank_if.sv
// Control/status bundle of the divider bank: enable, clear, terminal-count load, CE outputs.
interface ce_divider_bank_if
  import ce_divider_bank_pkg::*;
#(
  parameter int unsigned CH    = 2,
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             en;
  logic             sync_clr;
  logic [CH-1:0]    load;
  logic [WIDTH-1:0] div_in;
  logic [CH-1:0]    ce_pulse;
  logic [CH-1:0]    ce_toggle;

  modport master (
    output en, sync_clr, load, div_in,
    input  ce_pulse, ce_toggle
  );

  modport slave (
    input  en, sync_clr, load, div_in,
    output ce_pulse, ce_toggle
  );

endinterface

// File: rtl/ce_divider_channel.sv
// One divider channel: counter Q, terminal count T, registered CE pulse and optional toggle.
// Toggle flop is built only when CE_DIVIDER_TOGGLE_EN is defined; otherwise ce_toggle is tied low.
module ce_divider_channel
  import ce_divider_bank_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic             adv,
  output logic             term,
  output logic             ce_pulse,
  output logic             ce_toggle
);

  localparam logic [WIDTH-1:0] T_RST = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic             hit;

  assign hit  = adv && (q == t);
  // A clear or load in the terminal cycle swallows the event, so the next stage must not see it.
  assign term = hit && !load && !sync_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      t        <= T_RST;
      ce_pulse <= 1'b0;
    end else if (sync_clr) begin
      q        <= '0;
      ce_pulse <= 1'b0;
    end else if (load) begin
      t        <= div_in;
      q        <= '0;
      ce_pulse <= 1'b0;
    end else if (hit) begin
      q        <= '0;
      ce_pulse <= 1'b1;
    end else if (adv) begin
      q        <= q + WIDTH'(1);
      ce_pulse <= 1'b0;
    end else begin
      ce_pulse <= 1'b0;
    end
  end

`ifdef CE_DIVIDER_TOGGLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_toggle <= 1'b0;
    end else if (sync_clr) begin
      ce_toggle <= 1'b0;
    end else if (term) begin
      ce_toggle <= ~ce_toggle;
    end
  end
`else
  assign ce_toggle = 1'b0;
`endif

endmodule

// File: rtl/ce_divider_bank.sv
// Bank of CH clock-enable dividers, optionally cascaded as a prescaler chain.
// Toggle outputs depend on CE_DIVIDER_TOGGLE_EN (see ce_divider_channel).
module ce_divider_bank
  import ce_divider_bank_pkg::*;
#(
  parameter int unsigned CH          = 2,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEF_DIV,
  parameter int unsigned CASCADE     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  ce_divider_bank_if.slave   bus
);

  logic [CH-1:0] pulse;
  logic [CH-1:0] toggle;
  logic [CH-1:0] term_vec;
  logic          unused_term;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic adv_i;
    logic term_i;

    // Per-scope adv/term keep the cascade chain free of a self-referencing vector.
    if (i == 0 || CASCADE == 0) begin : g_adv
      assign adv_i = bus.en;
    end else begin : g_adv
      assign adv_i = bus.en && g_ch[i-1].term_i;
    end

    ce_divider_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .sync_clr  (bus.sync_clr),
      .load      (bus.load[i]),
      .div_in    (bus.div_in),
      .adv       (adv_i),
      .term      (term_i),
      .ce_pulse  (pulse[i]),
      .ce_toggle (toggle[i])
    );

    assign term_vec[i] = term_i;
  end

  assign unused_term   = ^term_vec;
  assign bus.ce_pulse  = pulse;
  assign bus.ce_toggle = toggle;

endmodule

// File: doc/ce_divider_bank.md
# ce_divider_bank

Parametrised bank of clock-enable generators, the successor to the fixed divide-by-20 000 001 toggle divider. It provides CH independent channels. Each channel has a runtime-loadable terminal count, a single-cycle enable pulse and an optional 50 % toggle output. Channels can optionally be cascaded into a prescaler chain. It sits beside the display and counter logic and feeds their CE inputs from the single system clock.

## Interface
- CH, 2: number of divider channels (1..8).
- WIDTH, 25: counter and terminal-count width in bits.
- DEFAULT_DIV, 20000000: terminal count loaded into every channel at reset; must fit WIDTH.
- CASCADE, 0: 0 = channels independent; 1 = channel i>0 advances only on channel i-1 terminal cycles.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- EN  in  1  global count enable.
- SYNC_CLR  in  1  synchronous clear of all counters and outputs.
- LOAD  in  CH  per-channel terminal-count write strobe.
- DIV_IN  in  WIDTH  terminal-count value written by LOAD.
- CE_PULSE  out  CH  one-cycle registered enable pulse per channel.
- CE_TOGGLE  out  CH  registered square wave per channel; flips on each terminal event.

## Operation
- Per channel i, hold counter Q[i] and terminal T[i], both WIDTH bits.
- adv[i] = EN and (CASCADE==0 or i==0 or term[i-1]).
- term[i] = adv[i] and (Q[i]==T[i]). This is combinational and feeds adv[i+1] in the same cycle.
- Per-channel update priority on each edge:
  - SYNC_CLR: Q<=0, CE_PULSE<=0, CE_TOGGLE<=0. T is kept.
  - LOAD[i]: T<=DIV_IN, Q<=0, CE_PULSE<=0. CE_TOGGLE holds. A terminal event in the same cycle is discarded.
  - term[i]: Q<=0, CE_PULSE<=1, CE_TOGGLE<=~CE_TOGGLE.
  - adv[i] only: Q<=Q+1, CE_PULSE<=0.
  - otherwise: Q holds, CE_PULSE<=0.
- Pulse period is T+1 advancing cycles. Toggle period is 2(T+1).
- T=0: pulse on every advancing cycle and toggle on every advancing cycle.
- Q never exceeds T in normal operation. Q wraps to 0 only through term, LOAD or SYNC_CLR, never through overflow.
- With CASCADE=1, a LOAD or SYNC_CLR on channel i-1 suppresses that cycle's term[i-1], so channel i does not advance that cycle.

## Timing
- Reset (RST_N low, asynchronous): Q=0, T=DEFAULT_DIV, CE_PULSE=0, CE_TOGGLE=0.
- Outputs are registered, with no combinational path from inputs to outputs.
- First pulse: with T=3 and EN high from the first edge after reset release, CE_PULSE is high in the cycle after the 4th edge. The pulse then repeats every 4 cycles.
- Reset asserted mid-count aborts immediately. After release, counting restarts from 0 with T=DEFAULT_DIV, and previously loaded values are lost.
- EN low: everything freezes, except that CE_PULSE drops to 0 at the next edge.

## Configuration
- CE_DIVIDER_TOGGLE_EN defined: the CE_TOGGLE registers and logic are built as described above.
- CE_DIVIDER_TOGGLE_EN undefined: the CE_TOGGLE port remains and is tied to 0, and no toggle flops are inferred. CE_PULSE behaviour is identical.

## Structure
- The shared package holds:
  - the default width constant (25);
  - the default divide constant (20000000);
  - the maximum channel count (8).
- Sub-module ce_divider_channel holds one channel's Q, T and outputs. It takes adv in and gives term out. The top instantiates CH copies in a generate loop and wires adv/term for cascade.

## Test plan
- Reset, then LOAD[0] with DIV_IN=3 and EN=1 -> CE_PULSE[0] period exactly 4 cycles; CE_TOGGLE[0] period 8 cycles.
- DIV_IN=0 on channel 1 -> CE_PULSE[1] constantly 1 while EN=1; CE_TOGGLE[1] flips every cycle.
- CASCADE=1 with T0=1 and T1=2 -> CE_PULSE[1] once per 6 cycles, coincident with every third CE_PULSE[0] event.
- LOAD[0] asserted in the exact terminal cycle -> no pulse that cycle, toggle unchanged, new period from the following cycle.
- EN dropped for 10 cycles mid-count -> pulse spacing stretched by exactly 10 cycles and no pulse during the gap; SYNC_CLR then zeroes all outputs while T values are kept.
- RST_N pulsed low asynchronously between edges -> outputs go to 0 at once; after release the first pulse arrives after DEFAULT_DIV+1 cycles (bench overrides DEFAULT_DIV=5 -> 6 cycles).
